// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: queue entry layout, store widths and the fence FSM states.
package store_buffer_pkg;

  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
  } sb_entry_t;

  typedef enum logic [1:0] {SB_IDLE, SB_FENCE, SB_DONE} sb_state_t;

  // True for an unknown width or an address not naturally aligned to the store width.
  function automatic logic store_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      STORE_BYTE: bad = 1'b0;
      STORE_HALF: bad = addr_lo[0];
      STORE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Generic in-order FIFO of store entries; also exposes every slot plus a per-slot occupancy mask.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        din,
  input  logic             pop,
  output sb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output sb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below the fill level.
  always_comb begin
    logic [PTR_W-1:0] off;
    off   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr;
      valid[i] = (CNT_W'(off) < count);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM-stage store path and DataMemory, with load hazard
// detection and a drain-all fence.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  logic [2:0]                   st_funct3,
  output logic                         st_err,
  input  logic                         ld_valid,
  input  logic [31:0]                  ld_addr,
  output logic                         ld_stall,
  input  logic                         drain_en,
  output logic                         dm_we,
  output logic [31:0]                  dm_addr,
  output logic [31:0]                  dm_wd,
  output logic [31:0]                  dm_instr,
  input  logic                         fence_req,
  output logic                         fence_done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  sb_state_t        state;
  sb_entry_t        push_entry;
  sb_entry_t        head;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full;
  logic             empty;
  logic             push;
  logic [DEPTH-1:0] unused_entry_bits;
  logic [1:0]       unused_ld_bits;

  assign st_err     = st_valid & store_bad(st_funct3, st_addr[1:0]);
  assign st_ready   = ~full & (state == SB_IDLE);
  assign push       = st_valid & st_ready & ~st_err;
  assign push_entry = '{addr: st_addr, data: st_data, funct3: st_funct3};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (push_entry),
    .pop     (dm_we),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .entries (entries),
    .valid   (valid)
  );

  assign dm_we    = ~empty & drain_en;
  assign dm_addr  = dm_we ? head.addr : '0;
  assign dm_wd    = dm_we ? head.data : '0;
  assign dm_instr = dm_we ? {17'b0, head.funct3, 12'b0} : '0;

  // The head being popped still matches: its write lands only at the coming edge.
  always_comb begin
    ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr[31:2] == ld_addr[31:2])) ld_stall = ld_valid;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_unused
    assign unused_entry_bits[g] = ^{entries[g].addr[1:0], entries[g].data, entries[g].funct3};
  end
  assign unused_ld_bits = ld_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SB_IDLE;
      fence_done <= 1'b0;
    end else begin
      fence_done <= 1'b0;
      case (state)
        SB_IDLE:  if (fence_req) state <= SB_FENCE;
        SB_FENCE: if (empty) begin
          state      <= SB_DONE;
          fence_done <= 1'b1;
        end
        SB_DONE:  state <= SB_IDLE;
        default:  state <= SB_IDLE;
      endcase
    end
  end

endmodule
